// File: rtl/data_mem_lsu_if.sv
// Request/response bus between the core MEM stage and data_mem_lsu.
// master = core side (drives requests), slave = memory side (drives responses).
interface data_mem_lsu_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_lsu.sv
// Byte-addressable data memory with RV32 load/store sizing, fixed response latency and
// misalign/reserved/range error reporting. Optional statistics counters are enabled by
// defining DMEM_STATS_EN; otherwise the stat_* outputs are tied to zero.
module data_mem_lsu #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned LATENCY     = 1,
    parameter int unsigned STAT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    data_mem_lsu_if.slave     bus,
    output logic [STAT_W-1:0] stat_loads,
    output logic [STAT_W-1:0] stat_stores,
    output logic [STAT_W-1:0] stat_errs
);
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W:0] ADDR_LIM = (ADDR_W + 1)'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic             accept;
    logic [IDX_W-1:0] idx;
    logic             misalign, reserved, out_of_range, req_err;
    logic [31:0]      rd_word, load_fmt, load_data;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [3:0]       be;
    logic [31:0]      wdata_rep;

    assign bus.req_ready = (state_q == StIdle) || (state_q == StResp);
    assign accept        = bus.req_valid && bus.req_ready;
    assign idx           = bus.req_addr[IDX_W+1:2];

    // Classify the request: misalignment, reserved size codes and range.
    always_comb begin
        misalign     = 1'b0;
        reserved     = 1'b0;
        out_of_range = ({1'b0, bus.req_addr} >= ADDR_LIM);
        unique case (bus.req_funct3)
            3'd0:       reserved = 1'b0;
            3'd1:       misalign = bus.req_addr[0];
            3'd2:       misalign = (bus.req_addr[1:0] != 2'b00);
            3'd4:       reserved = bus.req_we;
            3'd5:       begin
                            reserved = bus.req_we;
                            misalign = bus.req_addr[0];
                        end
            default:    reserved = 1'b1;
        endcase
        req_err = misalign || reserved || out_of_range;
    end

    // Read the addressed word and size/extend it for the load response.
    always_comb begin
        rd_word  = mem[idx];
        rd_byte  = rd_word[{bus.req_addr[1:0], 3'b000} +: 8];
        rd_half  = bus.req_addr[1] ? rd_word[31:16] : rd_word[15:0];
        load_fmt = 32'h0;
        unique case (bus.req_funct3)
            3'd0:    load_fmt = {{24{rd_byte[7]}}, rd_byte};
            3'd1:    load_fmt = {{16{rd_half[15]}}, rd_half};
            3'd2:    load_fmt = rd_word;
            3'd4:    load_fmt = {24'h0, rd_byte};
            3'd5:    load_fmt = {16'h0, rd_half};
            default: load_fmt = 32'h0;
        endcase
        load_data = (req_err || bus.req_we) ? 32'h0 : load_fmt;
    end

    // Byte enables and lane-replicated store data.
    always_comb begin
        be        = 4'b0000;
        wdata_rep = bus.req_wdata;
        unique case (bus.req_funct3[1:0])
            2'd0:    begin
                         be        = 4'b0001 << bus.req_addr[1:0];
                         wdata_rep = {4{bus.req_wdata[7:0]}};
                     end
            2'd1:    begin
                         be        = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                         wdata_rep = {2{bus.req_wdata[15:0]}};
                     end
            2'd2:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        if (!(accept && rst_n && bus.req_we && !req_err)) begin
            be = 4'b0000;
        end
    end

    // Array write at the accept edge; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end

    // State register and latency counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state: WAIT absorbs LATENCY-1 edges before RESP.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            StIdle, StResp: begin
                if (accept) begin
                    if (LATENCY > 1) begin
                        state_d = StWait;
                        wait_d  = 4'(LATENCY - 2);
                    end else begin
                        state_d = StResp;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (wait_q == 4'd0) state_d = StResp;
                else                wait_d  = wait_q - 4'd1;
            end
            default: state_d = StIdle;
        endcase
    end

    // Capture the response payload at accept; held until RESP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else if (accept) begin
            rdata_q <= load_data;
            err_q   <= req_err;
        end
    end

    assign bus.resp_valid = (state_q == StResp);
    assign bus.resp_rdata = bus.resp_valid ? rdata_q : 32'h0;
    assign bus.resp_err   = bus.resp_valid && err_q;

`ifdef DMEM_STATS_EN
    // Saturating per-accept statistics; erroneous requests also count by direction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_loads  <= '0;
            stat_stores <= '0;
            stat_errs   <= '0;
        end else if (accept) begin
            if (bus.req_we && !(&stat_stores)) stat_stores <= stat_stores + 1'b1;
            if (!bus.req_we && !(&stat_loads)) stat_loads <= stat_loads + 1'b1;
            if (req_err && !(&stat_errs))      stat_errs <= stat_errs + 1'b1;
        end
    end
`else
    assign stat_loads  = '0;
    assign stat_stores = '0;
    assign stat_errs   = '0;
`endif
endmodule
